// File: rtl/select_pkg.sv
// select_pkg: shared constants, state encoding and helpers for the select
// arbiter and the 8:1 select mux.
//   NREQ       number of requesters (8)
//   SEL_W      width of the select index (3)
//   IDLE/GRANT arbiter FSM state encoding
//   first_set  cyclic first-set search starting at a given index
package select_pkg;

  localparam int NREQ  = 8;
  localparam int SEL_W = 3;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Scan vec starting at 'start', wrapping modulo NREQ, and return the first
  // set position. The loop runs from the far end downwards so that the
  // closest hit to 'start' is the one left standing.
  function automatic pick_t first_set(input logic [NREQ-1:0]  vec,
                                      input logic [SEL_W-1:0] start);
    pick_t            r;
    logic [SEL_W-1:0] i;
    r.found = 1'b0;
    r.idx   = start;
    for (int k = NREQ - 1; k >= 0; k--) begin
      i = start + SEL_W'(k);
      if (vec[i]) begin
        r.found = 1'b1;
        r.idx   = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/select_arbiter_if.sv
// select_arbiter_if: requester/grant bundle between the requesters and the
// select arbiter.
//   req       per-requester request, bit i = requester i
//   din       packed operands, requester i at [i*WIDTH +: WIDTH]
//   flag      registered select index of the current owner
//   gnt       registered one-hot grant (0 while no owner)
//   valid     registered, high while an owner holds the grant
//   out       operand of the owner, 0 while valid is low
//   arb_state debug view of the arbiter FSM state (IDLE/GRANT)
// Handshake: a requester holds req[i] high for as long as it wants the mux;
// it owns the mux on every cycle where valid=1 and gnt[i]=1, and releases it
// by dropping req[i]. There is no separate ready: gnt is the acceptance.
interface select_arbiter_if #(
  parameter int WIDTH = 4
);
  import select_pkg::*;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;
  logic [SEL_W-1:0]      flag;
  logic [NREQ-1:0]       gnt;
  logic                  valid;
  logic [WIDTH-1:0]      out;
  logic [0:0]            arb_state;

  modport master (
    output req, din,
    input  flag, gnt, valid, out, arb_state
  );

  modport slave (
    input  req, din,
    output flag, gnt, valid, out, arb_state
  );

endinterface

// File: rtl/select_mux.sv
// select_mux: 8:1 WIDTH-bit operand mux steered by flag and gated by valid.
// Shared with the existing datapath.
//   din   packed operands, slot i at [i*WIDTH +: WIDTH]
//   flag  select index
//   valid when low, out is forced to 0
//   out   selected operand
module select_mux
  import select_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [NREQ*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]      flag,
  input  logic                  valid,
  output logic [WIDTH-1:0]      out
);

  always_comb begin
    out = '0;
    if (valid) begin
      out = din[flag*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/select_arbiter.sv
// select_arbiter: round-robin, lock-holding arbiter that sequences eight
// requesters onto the 8:1 select mux.
//   clk  system clock, all state on posedge
//   rst  synchronous active-high reset
//   bus  select_arbiter_if.slave (req, din in; flag, gnt, valid, out,
//        arb_state out)
// Parameters: WIDTH operand width, MAX_HOLD tenure limit (1..15).
// Optional feature: define SELECT_ARB_HOLD_LIMIT_EN to end every tenure after
// MAX_HOLD granted cycles; without it an owner keeps the grant until it
// drops its request.
module select_arbiter
  import select_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input logic             clk,
  input logic             rst,
  select_arbiter_if.slave bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("select_arbiter: MAX_HOLD must be within 1..15");
  end

  logic [0:0]       state_q, state_n;
  logic [SEL_W-1:0] flag_q, flag_n;
  logic [SEL_W-1:0] last_q, last_n;
  logic [NREQ-1:0]  gnt_q;
  logic             valid_q;
  logic             new_tenure;
  logic             limit;
  logic [NREQ-1:0]  others;
  pick_t            pick_idle;
  pick_t            pick_other;

`ifdef SELECT_ARB_HOLD_LIMIT_EN
  // Cycles already served in the current tenure, minus one. Saturates at 15.
  logic [3:0] hold_q;

  assign limit = (hold_q == 4'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (state_n != GRANT || new_tenure) begin
      hold_q <= '0;
    end else if (hold_q != 4'hF) begin
      hold_q <= hold_q + 4'd1;
    end
  end
`else
  assign limit = 1'b0;
`endif

  // While granted, last_q equals flag_q, so both searches start right after
  // the most recent owner; the owner itself is masked out of the
  // re-arbitration vector so it can only come back when nobody else waits.
  assign others     = bus.req & ~(NREQ'(1) << flag_q);
  assign pick_idle  = first_set(bus.req, last_q + SEL_W'(1));
  assign pick_other = first_set(others, flag_q + SEL_W'(1));

  always_comb begin
    state_n    = state_q;
    flag_n     = flag_q;
    new_tenure = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_idle.found) begin
          state_n    = GRANT;
          flag_n     = pick_idle.idx;
          new_tenure = 1'b1;
        end
      end
      GRANT: begin
        if (bus.req[flag_q] && !limit) begin
          state_n = GRANT;
        end else if (pick_other.found) begin
          flag_n     = pick_other.idx;
          new_tenure = 1'b1;
        end else if (bus.req[flag_q]) begin
          // Tenure limit hit with no competitor: re-grant the same owner.
          new_tenure = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    last_n = new_tenure ? flag_n : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      flag_q  <= '0;
      last_q  <= SEL_W'(NREQ - 1);
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      flag_q  <= flag_n;
      last_q  <= last_n;
      valid_q <= (state_n == GRANT);
      gnt_q   <= (state_n == GRANT) ? (NREQ'(1) << flag_n) : '0;
    end
  end

  assign bus.flag      = flag_q;
  assign bus.gnt       = gnt_q;
  assign bus.valid     = valid_q;
  assign bus.arb_state = state_q;

  select_mux #(
    .WIDTH (WIDTH)
  ) u_mux (
    .din   (bus.din),
    .flag  (flag_q),
    .valid (valid_q),
    .out   (bus.out)
  );

endmodule
